nvm_op_sequencer: RTL and testbench

// - Initiator for the 256x8 embedded NVM wrapper's generic port (addr/data/op/region/op_valid -> data/valid).
// - Accepts one host command (op, region, start addr, beat count) and issues it as N single-beat memory ops.
// - Keeps at most one op outstanding, increments the address per beat, and returns read data / pulls write data.
// - Sits between the host register bank and the memory wrapper.

---
 rtl/nvm_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_nvm_op_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_op_sequencer.sv
// Splits one host command into single-beat ops on the NVM wrapper port, one op in flight at a time.
// Build option NVM_SEQ_TIMEOUT_EN adds a WAIT timeout that aborts the command and raises o_err.
module nvm_op_sequencer #(
  parameter int NBW_DATA   = 8,
  parameter int NBW_LEN    = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_async_n,
  input  logic                i_start,
  input  logic [3:0]          i_cmd_op,
  input  logic                i_cmd_region,
  input  logic [NBW_DATA-1:0] i_cmd_addr,
  input  logic [NBW_LEN-1:0]  i_cmd_len,
  input  logic [NBW_DATA-1:0] i_wr_data,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  output logic [NBW_DATA-1:0] o_rd_data,
  output logic                o_rd_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [NBW_DATA-1:0] o_mem_addr,
  output logic [NBW_DATA-1:0] o_mem_data,
  output logic [3:0]          o_mem_op,
  output logic                o_mem_region,
  output logic                o_mem_op_valid,
  input  logic [NBW_DATA-1:0] i_mem_data,
  input  logic                i_mem_valid,
  output logic [2:0]          dbg_state
);

  // Write beats: i_wr_valid/o_wr_ready follow valid/ready rules; a beat transfers on a
  // rising clk edge where both are high, ready is only raised in FETCH, and valid is
  // ignored in every other state.

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
    $error("TMO_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [NBW_LEN-1:0]  beat_cnt;
  logic [NBW_DATA-1:0] nxt_addr;
  logic [3:0]          cmd_op;
  logic                cmd_region;

  logic                start_acc, wr_fire, mem_ack, tmo_hit;
  logic                busy_d, wr_ready_d, op_valid_d, done_d;
  logic [NBW_DATA-1:0] issue_addr;
  logic [3:0]          issue_op;
  logic                issue_region;

  assign start_acc = (state == S_IDLE) && i_start;
  assign wr_fire   = (state == S_FETCH) && i_wr_valid;
  // A zero-length command passes WAIT once with nothing outstanding, so no answer is consumed.
  assign mem_ack   = (state == S_WAIT) && i_mem_valid && (beat_cnt != '0);
  assign dbg_state = state;

`ifdef NVM_SEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
  logic [7:0] tmo_cnt;
  assign tmo_hit = (state == S_WAIT) && !i_mem_valid && (beat_cnt != '0) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) state <= S_IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (i_cmd_len == '0)          next_state = S_WAIT;
          else if (i_cmd_op == OP_WRITE) next_state = S_FETCH;
          else                           next_state = S_ISSUE;
        end
      end
      S_FETCH: if (i_wr_valid) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (beat_cnt == '0) begin
          next_state = S_DONE;
        end else if (i_mem_valid) begin
          if (beat_cnt == NBW_LEN'(1))  next_state = S_DONE;
          else if (cmd_op == OP_WRITE)  next_state = S_FETCH;
          else                          next_state = S_ISSUE;
        end else if (tmo_hit) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Flags are computed from next_state and registered, so they line up with the state register.
  always_comb begin
    busy_d     = (next_state != S_IDLE);
    wr_ready_d = (next_state == S_FETCH);
    op_valid_d = (next_state == S_ISSUE);
    done_d     = (next_state == S_DONE);
  end

  always_comb begin
    issue_addr   = nxt_addr;
    issue_op     = cmd_op;
    issue_region = cmd_region;
    if (start_acc) begin
      issue_addr   = i_cmd_addr;
      issue_op     = i_cmd_op;
      issue_region = i_cmd_region;
    end else if (mem_ack) begin
      issue_addr = nxt_addr + NBW_DATA'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      beat_cnt       <= '0;
      nxt_addr       <= '0;
      cmd_op         <= '0;
      cmd_region     <= 1'b0;
      o_busy         <= 1'b0;
      o_wr_ready     <= 1'b0;
      o_mem_op_valid <= 1'b0;
      o_done         <= 1'b0;
      o_rd_valid     <= 1'b0;
      o_rd_data      <= '0;
      o_mem_addr     <= '0;
      o_mem_data     <= '0;
      o_mem_op       <= '0;
      o_mem_region   <= 1'b0;
    end else begin
      o_busy         <= busy_d;
      o_wr_ready     <= wr_ready_d;
      o_mem_op_valid <= op_valid_d;
      o_done         <= done_d;
      o_rd_valid     <= 1'b0;
      if (start_acc) begin
        beat_cnt   <= i_cmd_len;
        nxt_addr   <= i_cmd_addr;
        cmd_op     <= i_cmd_op;
        cmd_region <= i_cmd_region;
      end
      if (wr_fire) o_mem_data <= i_wr_data;
      // Address/op/region only move when the next op is launched, so they stay put between ISSUEs.
      if (op_valid_d) begin
        o_mem_addr   <= issue_addr;
        o_mem_op     <= issue_op;
        o_mem_region <= issue_region;
      end
      if (mem_ack) begin
        beat_cnt <= beat_cnt - NBW_LEN'(1);
        nxt_addr <= nxt_addr + NBW_DATA'(1);
        if (cmd_op == OP_READ) begin
          o_rd_valid <= 1'b1;
          o_rd_data  <= i_mem_data;
        end
      end
    end
  end

`ifdef NVM_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      tmo_cnt <= '0;
      o_err   <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_WAIT && next_state == S_WAIT) ? tmo_cnt + 8'd1 : 8'd0;
      if (start_acc)    o_err <= 1'b0;
      else if (tmo_hit) o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nvm_op_sequencer.sv
// Bench for nvm_op_sequencer: wrapper responder with memory, event monitor, and a per-command
// reference built from address/beat arithmetic (timeout case only with NVM_SEQ_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_nvm_op_sequencer;
  localparam int W = 8;
  localparam int TB_TMO = 10;
  localparam logic [3:0] OP_RD = 4'h1;
  localparam logic [3:0] OP_WR = 4'h2;

  logic         clk = 1'b0;
  logic         rst_async_n = 1'b0;
  logic         i_start = 1'b0;
  logic [3:0]   i_cmd_op = '0;
  logic         i_cmd_region = 1'b0;
  logic [W-1:0] i_cmd_addr = '0;
  logic [W-1:0] i_cmd_len = '0;
  logic [W-1:0] i_wr_data = '0;
  logic         i_wr_valid = 1'b0;
  logic         o_wr_ready;
  logic [W-1:0] o_rd_data;
  logic         o_rd_valid, o_busy, o_done, o_err;
  logic [W-1:0] o_mem_addr, o_mem_data;
  logic [3:0]   o_mem_op;
  logic         o_mem_region, o_mem_op_valid;
  logic [W-1:0] i_mem_data = '0;
  logic         i_mem_valid = 1'b0;
  logic [2:0]   dbg_state;

  nvm_op_sequencer #(.NBW_DATA(W), .NBW_LEN(8), .TMO_CYCLES(TB_TMO)) dut (
    .clk(clk), .rst_async_n(rst_async_n), .i_start(i_start), .i_cmd_op(i_cmd_op),
    .i_cmd_region(i_cmd_region), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_op(o_mem_op),
    .o_mem_region(o_mem_region), .o_mem_op_valid(o_mem_op_valid), .i_mem_data(i_mem_data),
    .i_mem_valid(i_mem_valid), .dbg_state(dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // wrapper model: answers every op resp_k cycles after op_valid
  logic [W-1:0] mem [0:1][0:255];
  int  resp_k = 2;
  bit  resp_mute = 0;
  bit  spur_once = 0;
  int  resp_cnt = 0;
  logic [W-1:0] resp_data = '0;
  initial forever begin
    @(negedge clk);
    i_mem_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        i_mem_valid = 1'b1;
        i_mem_data  = resp_data;
      end
    end
    if (o_mem_op_valid) begin
      if (o_mem_op == OP_WR) mem[o_mem_region][o_mem_addr] = o_mem_data;
      resp_data = mem[o_mem_region][o_mem_addr];
      if (!resp_mute) resp_cnt = resp_k;
      if (spur_once) begin
        spur_once   = 0;
        i_mem_valid = 1'b1;
        i_mem_data  = 8'hEE;
      end
    end
  end

  // monitor
  logic [W-1:0] ob_addr[$], ob_data[$], ob_rd[$];
  logic [3:0]   ob_op[$];
  logic         ob_reg[$];
  int           ob_cyc[$], rd_cyc[$];
  int  done_cnt = 0, done_cyc = 0, wrr_cnt = 0;
  logic busy_at_done = 1'b0, err_at_done = 1'b0;
  initial forever begin
    @(negedge clk);
    if (o_mem_op_valid) begin
      ob_addr.push_back(o_mem_addr); ob_data.push_back(o_mem_data);
      ob_op.push_back(o_mem_op); ob_reg.push_back(o_mem_region); ob_cyc.push_back(cyc);
    end
    if (o_rd_valid) begin ob_rd.push_back(o_rd_data); rd_cyc.push_back(cyc); end
    if (o_done) begin done_cnt++; done_cyc = cyc; busy_at_done = o_busy; err_at_done = o_err; end
    if (o_wr_ready) wrr_cnt++;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_obs();
    ob_addr.delete(); ob_data.delete(); ob_rd.delete(); ob_op.delete();
    ob_reg.delete(); ob_cyc.delete(); rd_cyc.delete(); wrr_cnt = 0;
  endtask

  function automatic logic [63:0] all_outs();
    return {26'd0, o_wr_ready, o_rd_data, o_rd_valid, o_busy, o_done, o_err, o_mem_addr,
            o_mem_data, o_mem_op, o_mem_region, o_mem_op_valid, dbg_state};
  endfunction

  task automatic issue_start(input logic [3:0] op, input logic rg, input logic [W-1:0] addr,
                             input int len, output int st);
    i_cmd_op = op; i_cmd_region = rg; i_cmd_addr = addr; i_cmd_len = 8'(len);
    i_start = 1'b1;
    i_wr_valid = 1'b1; i_wr_data = 8'hEE;  // stray write beat in IDLE must be ignored
    st = cyc;
    tick();
    i_start = 1'b0; i_wr_valid = 1'b0;
    i_cmd_addr = 8'($urandom_range(0, 255)); i_cmd_len = 8'($urandom_range(0, 255));
  endtask

  // one command: drive it, then compare every observed event against the arithmetic reference
  task automatic run_cmd(input logic [3:0] op, input logic rg, input logic [W-1:0] addr,
                         input int len, input int k, input int d, input bit poke,
                         input logic [W-1:0] wdata[$]);
    logic [W-1:0] exp_addr_q[$];
    logic [W-1:0] exp_q[$];
    int st, base_done, n, per, pre;
    bit wr;
    wr = (op == OP_WR);
    for (int i = 0; i < len; i++) begin
      logic [W-1:0] a;
      a = addr + 8'(i);
      exp_addr_q.push_back(a);
      if (wr) exp_q.push_back(wdata[i]);
      else if (op == OP_RD) exp_q.push_back(mem[rg][a]);
    end
    per = k + 1 + (wr ? d + 1 : 0);
    pre = wr ? d + 1 : 0;
    resp_k = k;
    clear_obs();
    base_done = done_cnt;
    issue_start(op, rg, addr, len, st);
    if (poke) begin
      tick();
      i_start = 1'b1; i_cmd_op = OP_WR; i_cmd_addr = 8'h80; i_cmd_len = 8'd7;
      spur_once = 1;
      tick();
      i_start = 1'b0;
    end
    if (wr) begin
      for (int i = 0; i < len; i++) begin
        n = 0;
        while (!o_wr_ready && n < 200) begin tick(); n++; end
        check("wr_ready_timeout", 64'(n < 200), 64'd1);
        repeat (d) tick();
        i_wr_valid = 1'b1; i_wr_data = wdata[i];
        tick();
        i_wr_valid = 1'b0; i_wr_data = 8'($urandom_range(0, 255));
      end
    end
    n = 0;
    while (done_cnt == base_done && n < 400) begin tick(); n++; end
    check("done_timeout", 64'(n < 400), 64'd1);
    // start raised during the o_done cycle must be dropped
    i_start = 1'b1; i_cmd_op = OP_RD; i_cmd_len = 8'd1;
    tick();
    i_start = 1'b0;
    check("busy_at_done", 64'(busy_at_done), 64'd1);
    check("busy_after_done", 64'(o_busy), 64'd0);
    repeat (3) tick();
    check("done_count", 64'(done_cnt - base_done), 64'd1);
    check("err_at_done", 64'(err_at_done), 64'd0);
    check("op_count", 64'(ob_addr.size()), 64'(len));
    check("done_cycle", 64'(done_cyc - st), 64'(len == 0 ? 2 : 1 + len * per));
    check("wr_ready_cycles", 64'(wrr_cnt), 64'(wr ? len * (d + 1) : 0));
    for (int i = 0; i < len && i < ob_addr.size(); i++) begin
      check($sformatf("addr[%0d]", i), 64'(ob_addr[i]), 64'(exp_addr_q[i]));
      check($sformatf("op[%0d]", i), 64'(ob_op[i]), 64'(op));
      check($sformatf("region[%0d]", i), 64'(ob_reg[i]), 64'(rg));
      check($sformatf("op_cycle[%0d]", i), 64'(ob_cyc[i] - st), 64'(1 + pre + i * per));
      if (wr) check($sformatf("wr_data[%0d]", i), 64'(ob_data[i]), 64'(exp_q[i]));
    end
    check("rd_count", 64'(ob_rd.size()), 64'(op == OP_RD ? len : 0));
    if (op == OP_RD) begin
      for (int i = 0; i < len && i < ob_rd.size(); i++) begin
        check($sformatf("rd_data[%0d]", i), 64'(ob_rd[i]), 64'(exp_q[i]));
        check($sformatf("rd_cycle[%0d]", i), 64'(rd_cyc[i] - st), 64'(1 + (i + 1) * per));
      end
    end
  endtask

  logic [W-1:0] no_data[$];
  logic [W-1:0] wd[$];
  int st;
  int len;

  initial begin : watchdog
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    for (int r = 0; r < 2; r++)
      for (int a = 0; a < 256; a++) mem[r][a] = 8'($urandom_range(0, 255));

    // reset
    repeat (3) tick();
    check("reset_outputs", all_outs(), 64'd0);
    rst_async_n = 1'b1;
    tick();
    check("idle_outputs", all_outs(), 64'd0);

    // directed read with wrapper latency 2
    run_cmd(OP_RD, 1'b0, 8'h10, 3, 2, 0, 1'b0, no_data);

    // write across the address wrap with slow write data
    wd = '{8'hA5, 8'h5A, 8'h3C};
    run_cmd(OP_WR, 1'b0, 8'hFE, 3, 2, 4, 1'b0, wd);
    check("mem_FE", 64'(mem[0][8'hFE]), 64'h A5);
    check("mem_FF", 64'(mem[0][8'hFF]), 64'h5A);
    check("mem_00", 64'(mem[0][8'h00]), 64'h3C);

    // zero-length read
    run_cmd(OP_RD, 1'b0, 8'h20, 0, 1, 0, 1'b0, no_data);

    // busy start poke and spurious i_mem_valid in ISSUE
    run_cmd(OP_RD, 1'b1, 8'h30, 4, 3, 0, 1'b1, no_data);

    // opaque op and read back across the wrap
    run_cmd(4'h3, 1'b1, 8'h44, 2, 1, 0, 1'b0, no_data);
    run_cmd(OP_RD, 1'b0, 8'hFE, 3, 1, 0, 1'b0, no_data);

    // reset in the middle of beat 2 of 4
    resp_k = 3;
    clear_obs();
    issue_start(OP_RD, 1'b0, 8'h40, 4, st);
    while (cyc < st + 6) tick();
    check("pre_reset_ops", 64'(ob_addr.size()), 64'd2);
    check("pre_reset_rds", 64'(ob_rd.size()), 64'd1);
    rst_async_n = 1'b0;
    tick();
    check("midreset_outputs", all_outs(), 64'd0);
    tick();
    rst_async_n = 1'b1;
    clear_obs();
    repeat (6) tick();
    check("late_valid_rds", 64'(ob_rd.size()), 64'd0);
    check("late_valid_ops", 64'(ob_addr.size()), 64'd0);
    check("late_valid_busy", 64'(o_busy), 64'd0);

`ifdef NVM_SEQ_TIMEOUT_EN
    resp_mute = 1;
    clear_obs();
    len = done_cnt;
    issue_start(OP_RD, 1'b0, 8'h50, 3, st);
    for (int n = 0; n < 40 && done_cnt == len; n++) tick();
    check("tmo_done_count", 64'(done_cnt - len), 64'd1);
    check("tmo_done_cycle", 64'(done_cyc - st), 64'(2 + TB_TMO));
    check("tmo_err_at_done", 64'(err_at_done), 64'd1);
    check("tmo_ops", 64'(ob_addr.size()), 64'd1);
    repeat (3) tick();
    check("tmo_err_sticky", 64'(o_err), 64'd1);
    resp_mute = 0;
    resp_k = 1;
    issue_start(OP_RD, 1'b0, 8'h60, 1, st);
    check("tmo_err_cleared", 64'(o_err), 64'd0);
    repeat (6) tick();
`endif

    // randomized commands
    for (int t = 0; t < 14; t++) begin
      logic [3:0] op;
      case ($urandom_range(0, 3))
        0: op = OP_RD;
        1: op = OP_WR;
        2: op = 4'h3;
        default: op = 4'hF;
      endcase
      len = $urandom_range(0, 6);
      wd.delete();
      for (int i = 0; i < len; i++) wd.push_back(8'($urandom_range(0, 255)));
      run_cmd(op, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), len,
              $urandom_range(1, 4), $urandom_range(0, 3), 1'b0, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
